seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the team's seven-segment scan driver (seg/ans outputs of the ALU top).
- Samples multiplexed seg/ans lines, filters scan transitions, decodes segment patterns back to hex nibbles, and assembles a 32-bit displayed value.
- Used as a self-checking monitor in ALU/top benches and as a loopback checker on board.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples of the {ans, seg} pair required before capture (≥2).
- ACTIVE_LOW, 1, 1 = seg and ans pins are active-low (board convention); 0 = active-high.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- seg  in  7  segment lines, seg[0]=a … seg[6]=g.
- ans  in  8  digit enables; ans[i] selects digit i, and digit 0 is the rightmost digit.
- value  out  32  last complete frame; digit i occupies value[4i+3:4i].
- digit_valid  out  8  slots captured in the current, incomplete frame.
- frame_valid  out  1  one-cycle pulse when value updates.
- err  out  1  one-cycle pulse on an illegal sample.

Behaviour:
- Reset (async, immediate):
  - value=0, digit_valid=0, frame_valid=0, err=0.
  - FSM goes to IDLE, stability counter=0, sample registers=0.
- Input normalisation:
  - If ACTIVE_LOW=1, seg and ans are inverted internally.
  - All following rules use active-high values.
  - Inputs are registered once (1-cycle input latency).
- Decode table, active-high gfedcba to nibble:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - A:77, b:7C, C:39, d:5E, E:79, F:71.
  - 00 = blank: slot marked captured with nibble 0, no error.
  - Any other pattern is illegal.
- FSM:
  - IDLE:
    - Registered ans==0 → stay.
    - ans has exactly one bit set → SETTLE, counter=1.
    - ans has more than one bit set → err pulse, stay in IDLE.
  - SETTLE:
    - Sample equals previous sample → counter++.
    - Sample differs → counter=1 and re-evaluate as from IDLE.
    - Counter reaches STABLE_CYCLES → capture and go to HOLD.
    - Legal pattern: write nibble to its slot, set digit_valid[i].
    - Illegal pattern: err pulse, slot untouched.
  - HOLD:
    - Stay while the sample is unchanged; no re-capture.
    - Any change → treated as from IDLE on the same cycle.
- Frame completion:
  - Completes on the cycle the capture makes digit_valid all-ones.
  - Next edge: value ← assembled nibbles, frame_valid=1 for one cycle, digit_valid cleared.
- Re-capture of an already-valid slot before frame completion overwrites its nibble (latest wins); no error.
- value holds its old content between frames.
- Total latency, last stable sample at pins → frame_valid: STABLE_CYCLES+2 cycles.
- Simultaneous err and frame completion cannot occur (an illegal capture never sets a slot).
- Reset during a partial frame discards it; value returns to 0.

Optional Feature:
- Macro: SEG_SCAN_ERRCNT_EN.
- Defined:
  - Adds output err_count [7:0].
  - Increments on every err pulse and saturates at 8'hFF.
  - Cleared by reset.
  - Adds input err_clr (1 bit, synchronous clear; clear wins over a same-cycle increment).
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package seg_scan_pkg holds:
  - The FSM state enum (IDLE, SETTLE, HOLD).
  - The 16-entry segment pattern constants and the BLANK constant.
  - A pure decode function returning {legal, nibble}.
- One sub-module seg_pattern_decode: combinational 7→{legal, blank, nibble[3:0]}.
  - Shared with the existing display driver's bench for cross-checking.

Test Plan (STABLE_CYCLES=4, ACTIVE_LOW=1):
- Single digit: ans=8'hFE, seg=7'h79 (active-low "1") held 6 cycles → digit_valid=8'h01; value stays 0; no frame_valid.
- Full frame: digit i shows i+1, 5 cycles per digit, i=0..7 → exactly one frame_valid, value=32'h87654321, digit_valid back to 0.
- Glitch filter: each digit held only 3 cycles → no capture, digit_valid stays 0, err never pulses.
- Illegal pattern on ans=8'hFB, seg=~7'h49 held 4 cycles → one err pulse, digit_valid[2] stays 0. Two-hot ans=8'hFC → err pulse.
- Blank plus overwrite: digit 3 shows seg=7'h7F (blank), then digits 0–7 run with digit 3=F → value[15:12]=4'hF; a second frame with digit 3 blank → value[15:12]=0.
- Reset mid-frame after 5 digits → all outputs 0 immediately; a full new frame "00000000" → value=0 with one frame_valid. With SEG_SCAN_ERRCNT_EN, 300 errors → err_count=8'hFF; err_clr → 0.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// rtl/seg_scan_decoder_pkg.sv - shared FSM state type, segment pattern table and decode function
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high gfedcba patterns; entry n displays hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    res = (seg == SEG_BLANK) ? 5'h10 : 5'h00;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[4'(i)]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scan pin and result bundle; SEG_SCAN_ERRCNT_EN adds err_clr/err_count
interface seg_scan_decoder_if;

  logic [6:0]  seg;
  logic [7:0]  ans;
  logic [31:0] value;
  logic [7:0]  digit_valid;
  logic        frame_valid;
  logic        err;
`ifdef SEG_SCAN_ERRCNT_EN
  logic        err_clr;
  logic [7:0]  err_count;

  modport master (output seg, ans, err_clr,
                  input  value, digit_valid, frame_valid, err, err_count);
  modport slave  (input  seg, ans, err_clr,
                  output value, digit_valid, frame_valid, err, err_count);
`else
  modport master (output seg, ans,
                  input  value, digit_valid, frame_valid, err);
  modport slave  (input  seg, ans,
                  output value, digit_valid, frame_valid, err);
`endif

endinterface

// File: rtl/seg_scan_decoder_pattern_decode.sv
// rtl/seg_scan_decoder_pattern_decode.sv - combinational segment pattern to {legal, blank, nibble}
import seg_scan_pkg::*;

module seg_pattern_decode (
  input  logic [6:0] seg_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] nibble_o
);

  logic [4:0] dec;

  always_comb begin
    dec = seg_decode(seg_i);
  end

  assign legal_o  = dec[4];
  assign nibble_o = dec[3:0];
  assign blank_o  = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scan-line monitor rebuilding the 8-digit display value
// Optional SEG_SCAN_ERRCNT_EN adds a saturating error counter with synchronous clear.
import seg_scan_pkg::*;

module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  seg_scan_decoder_if.slave bus
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]    seg_q;
  logic [7:0]    ans_q;
  logic [14:0]   last_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   nib_q, nib_d, value_q, value_d;
  logic [7:0]    dv_q, dv_d;
  logic          fv_q, fv_d, err_q, err_d;

  logic          ans_zero, ans_one, ans_multi, same, eval, capture, dv_full;
  logic          legal, blank;
  logic [3:0]    nibble, cap_nib;
  logic [2:0]    slot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q  <= '0;
      ans_q  <= '0;
      last_q <= '0;
    end else begin
      seg_q  <= ACTIVE_LOW ? ~bus.seg : bus.seg;
      ans_q  <= ACTIVE_LOW ? ~bus.ans : bus.ans;
      last_q <= {ans_q, seg_q};
    end
  end

  assign ans_zero  = (ans_q == 8'h00);
  assign ans_one   = $onehot(ans_q);
  assign ans_multi = !ans_zero && !ans_one;
  assign same      = ({ans_q, seg_q} == last_q);
  assign cnt_inc   = cnt_q + CW'(1);
  // Any change of the sample is judged afresh, exactly as from IDLE.
  assign eval      = (state_q == IDLE) || !same;
  assign capture   = (state_q == SETTLE) && same && (cnt_inc == CNT_MAX);
  assign dv_full   = &dv_q;

  always_comb begin
    slot = '0;
    for (int i = 0; i < 8; i++) begin
      if (ans_q[i]) slot = 3'(i);
    end
  end

  seg_pattern_decode u_decode (
    .seg_i    (seg_q),
    .legal_o  (legal),
    .blank_o  (blank),
    .nibble_o (nibble)
  );

  assign cap_nib = blank ? 4'h0 : nibble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (eval) begin
      state_d = ans_one ? SETTLE : IDLE;
      cnt_d   = ans_one ? CW'(1) : '0;
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_inc;
      if (cnt_inc == CNT_MAX) state_d = HOLD;
    end
  end

  always_comb begin
    err_d   = (eval && ans_multi) || (capture && !legal);
    fv_d    = dv_full;
    value_d = dv_full ? nib_q : value_q;
    dv_d    = dv_full ? 8'h00 : dv_q;
    nib_d   = nib_q;
    if (capture && legal) begin
      dv_d[slot]               = 1'b1;
      nib_d[{slot, 2'b00} +: 4] = cap_nib;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nib_q   <= '0;
      value_q <= '0;
      dv_q    <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      nib_q   <= nib_d;
      value_q <= value_d;
      dv_q    <= dv_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = dv_q;
  assign bus.frame_valid = fv_q;
  assign bus.err         = err_q;

`ifdef SEG_SCAN_ERRCNT_EN
  logic [7:0] ecnt_q;

  // Counts alongside the err pulse; clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecnt_q <= '0;
    end else if (bus.err_clr) begin
      ecnt_q <= '0;
    end else if (err_d && (ecnt_q != 8'hFF)) begin
      ecnt_q <= ecnt_q + 8'd1;
    end
  end

  assign bus.err_count = ecnt_q;
`endif

endmodule
